// File: rtl/burst_rr_arbiter.sv
// Purpose: N-way arbiter with sticky grants capped by a burst limit, fixed-priority or round-robin.
// Latency: zero cycles; the grant is combinational from requests_i and the registered holder/burst state.
// Backpressure: none; requests are level-sensitive and stay pending until granted.
//
// Ports:
//   clk_i, rst_ni   clock and asynchronous active-low reset
//   mode_i          0 = fixed priority (lowest index wins), 1 = round-robin after the last holder
//   requests_i      per-requester request level
//   lock_i          per-requester burst lock (present only with BURST_RR_ARBITER_LOCK_EN defined)
//   grant_o         one-hot grant, or all zero
//   grant_valid_o   OR of grant_o
//   grant_idx_o     binary index of the granted requester, 0 when there is no grant
//
// Optional feature macro: BURST_RR_ARBITER_LOCK_EN. When it is defined, a locked holder
// keeps the grant past MaxBurst.
module burst_rr_arbiter #(
  parameter int unsigned Count    = 4,
  parameter int unsigned MaxBurst = 8,
  localparam int unsigned IdxW    = (Count > 1) ? $clog2(Count) : 1,
  localparam int unsigned BurstW  = $clog2(MaxBurst + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              mode_i,
  input  logic [Count-1:0]  requests_i,
`ifdef BURST_RR_ARBITER_LOCK_EN
  input  logic [Count-1:0]  lock_i,
`endif
  output logic [Count-1:0]  grant_o,
  output logic              grant_valid_o,
  output logic [IdxW-1:0]   grant_idx_o
);

  localparam logic [BurstW-1:0] BurstMax = BurstW'(MaxBurst);
  localparam logic [BurstW-1:0] BurstOne = BurstW'(1);

  logic              valid_q,  valid_d;
  logic [IdxW-1:0]   holder_q, holder_d;
  logic [BurstW-1:0] burst_q,  burst_d;

  logic [Count-1:0]  others;
  logic [Count-1:0]  cand;
  logic [Count-1:0]  grant_vec;
  logic [IdxW-1:0]   grant_idx;
  logic [IdxW-1:0]   winner;
  logic              holder_req;
  logic              exhausted;
  logic              locked;
  logic              hold;
  logic              found;
  int                idx;

  always_comb begin
    others     = requests_i;
    others[holder_q] = 1'b0;
    holder_req = requests_i[holder_q];
    exhausted  = (burst_q >= BurstMax);
`ifdef BURST_RR_ARBITER_LOCK_EN
    locked     = lock_i[holder_q];
`else
    locked     = 1'b0;
`endif
    hold       = valid_q && holder_req && (!exhausted || (others == '0) || locked);

    // An exhausted holder that is still requesting is excluded, so the grant really moves on.
    cand = (valid_q && holder_req && exhausted) ? others : requests_i;

    winner = '0;
    found  = 1'b0;
    idx    = 0;
    if (!mode_i) begin
      // Scan downwards so the lowest set index is the last one written.
      for (int i = int'(Count) - 1; i >= 0; i--) begin
        if (cand[i]) winner = IdxW'(i);
      end
    end else begin
      // Search starts just after the holder and wraps; the holder itself is searched last.
      for (int i = 1; i <= int'(Count); i++) begin
        idx = int'(holder_q) + i;
        if (idx >= int'(Count)) idx = idx - int'(Count);
        if (!found && cand[idx]) begin
          winner = IdxW'(idx);
          found  = 1'b1;
        end
      end
    end

    valid_d   = valid_q;
    holder_d  = holder_q;
    burst_d   = burst_q;
    grant_vec = '0;
    grant_idx = '0;

    if (hold) begin
      grant_vec[holder_q] = 1'b1;
      grant_idx           = holder_q;
      if (locked) begin
        burst_d = exhausted ? BurstMax : (burst_q + BurstOne);
      end else begin
        // A sole remaining requester past its limit starts a fresh burst.
        burst_d = exhausted ? BurstOne : (burst_q + BurstOne);
      end
    end else if (requests_i != '0) begin
      grant_vec[winner] = 1'b1;
      grant_idx         = winner;
      holder_d          = winner;
      valid_d           = 1'b1;
      burst_d           = BurstOne;
    end else begin
      // Holder is kept so round-robin resumes after the last owner.
      valid_d = 1'b0;
      burst_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= 1'b0;
      holder_q <= IdxW'(Count - 1);
      burst_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      holder_q <= holder_d;
      burst_q  <= burst_d;
    end
  end

  // Outputs are forced quiet while reset is asserted, even though the decision logic runs.
  assign grant_o       = rst_ni ? grant_vec : '0;
  assign grant_valid_o = rst_ni && (grant_vec != '0);
  assign grant_idx_o   = rst_ni ? grant_idx : '0;

endmodule

// File: tb/tb_burst_rr_arbiter.sv
// Purpose: directed self-checking bench for burst_rr_arbiter (Count=4, MaxBurst=8).
// Latency: grants are checked combinationally in the same cycle their requests are driven.
// Backpressure: not applicable; inputs are driven one cycle at a time.
module tb_burst_rr_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       mode_i;
  logic [3:0] requests_i;
  logic [3:0] grant_o;
  logic       grant_valid_o;
  logic [1:0] grant_idx_o;
`ifdef BURST_RR_ARBITER_LOCK_EN
  logic [3:0] lock_i;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  burst_rr_arbiter #(.Count(4), .MaxBurst(8)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .mode_i        (mode_i),
    .requests_i    (requests_i),
`ifdef BURST_RR_ARBITER_LOCK_EN
    .lock_i        (lock_i),
`endif
    .grant_o       (grant_o),
    .grant_valid_o (grant_valid_o),
    .grant_idx_o   (grant_idx_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) if (v[i]) r = 2'(i);
    return r;
  endfunction

  // Called 1 time unit after a rising edge: drive, settle, check, advance one cycle.
  task automatic step(input logic [3:0] req, input logic mode, input logic [3:0] exp,
                      input string tag);
    requests_i = req;
    mode_i     = mode;
    #3;
    chk({tag, "_grant"}, 32'(grant_o), 32'(exp));
    chk({tag, "_vld"},   32'(grant_valid_o), 32'(exp != 4'b0));
    chk({tag, "_idx"},   32'(grant_idx_o), 32'(onehot_idx(exp)));
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni     = 1'b0;
    mode_i     = 1'b1;
    requests_i = 4'b1111;
`ifdef BURST_RR_ARBITER_LOCK_EN
    lock_i     = 4'b0000;
`endif
    #2;
    chk("rst_grant", 32'(grant_o), 32'h0);
    chk("rst_vld",   32'(grant_valid_o), 32'h0);
    chk("rst_idx",   32'(grant_idx_o), 32'h0);
    @(posedge clk_i);
    #1;
    chk("rst_hold_grant", 32'(grant_o), 32'h0);
    rst_ni = 1'b1;

    // Zero-latency first grant: holder resets to 3, so round-robin lands on req1.
    step(4'b0110, 1'b1, 4'b0010, "first");
    step(4'b0000, 1'b1, 4'b0000, "idle0");

    // Park the holder on req3 so the next round-robin pass starts at req0.
    step(4'b1000, 1'b1, 4'b1000, "park3");
    step(4'b0000, 1'b1, 4'b0000, "idle1");

    // Full rotation: 8 beats each for req0..req3, then back to req0 with no gaps.
    for (int k = 0; k < 40; k++) begin
      step(4'b1111, 1'b1, 4'b0001 << ((k / 8) % 4), $sformatf("rot%0d", k));
    end
    step(4'b0000, 1'b1, 4'b0000, "idle2");

    // Sole requester keeps the grant across burst restarts.
    for (int k = 0; k < 20; k++) begin
      step(4'b0100, 1'b1, 4'b0100, $sformatf("sole%0d", k));
    end
    step(4'b0000, 1'b1, 4'b0000, "idle3");

    // Early release: req0 takes 3 beats in fixed priority, drops, req1 takes over same cycle.
    step(4'b1011, 1'b0, 4'b0001, "er_a");
    step(4'b1011, 1'b0, 4'b0001, "er_b");
    step(4'b1011, 1'b0, 4'b0001, "er_c");
    for (int k = 0; k < 9; k++) begin
      step(4'b1010, 1'b1, (k < 8) ? 4'b0010 : 4'b1000, $sformatf("er_run%0d", k));
    end
    step(4'b0000, 1'b1, 4'b0000, "idle4");

    // Fixed priority: req1 holds 8, req3 gets one beat, req1 regains.
    for (int k = 0; k < 9; k++) begin
      step(4'b1010, 1'b0, (k < 8) ? 4'b0010 : 4'b1000, $sformatf("fp%0d", k));
    end
    step(4'b0010, 1'b0, 4'b0010, "fp_regain");
    // Mode flip mid-burst does not cut the hold; the burst ends after 8 beats.
    for (int k = 0; k < 3; k++) step(4'b1010, 1'b0, 4'b0010, $sformatf("mf_a%0d", k));
    for (int k = 0; k < 4; k++) step(4'b1010, 1'b1, 4'b0010, $sformatf("mf_b%0d", k));
    step(4'b1010, 1'b1, 4'b1000, "mf_switch");
    step(4'b0000, 1'b1, 4'b0000, "idle5");

`ifdef BURST_RR_ARBITER_LOCK_EN
    step(4'b0100, 1'b0, 4'b0100, "lk_take");
    lock_i = 4'b0100;
    for (int k = 0; k < 30; k++) step(4'b1111, 1'b1, 4'b0100, $sformatf("lk%0d", k));
    lock_i = 4'b0000;
    step(4'b1111, 1'b1, 4'b1000, "lk_release");
    step(4'b0000, 1'b1, 4'b0000, "idle6");
`endif

    // Asynchronous reset mid-activity silences the grant immediately.
    requests_i = 4'b0001;
    mode_i     = 1'b0;
    #3;
    chk("pre_arst_grant", 32'(grant_o), 32'h1);
    rst_ni = 1'b0;
    #1;
    chk("arst_grant", 32'(grant_o), 32'h0);
    chk("arst_idx",   32'(grant_idx_o), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
